led_pwm_driver: RTL

//  Memory-mapped LED controller on the data-memory bus; generalised successor to the plain LED latch.

---
 rtl/led_pwm_driver.sv | 100 ++++++++++
 1 files changed

// File: rtl/led_pwm_driver.sv
// Memory-mapped LED controller: per-LED enable, global PWM brightness and per-LED blink.
// Define LED_BLINK_EN to build the blink engine; otherwise blink_phase is tied to 1.
module led_pwm_driver #(
    parameter int NUM_LEDS   = 16,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 24,
    parameter int BLINK_RST  = 12500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         writeData,
    input  logic                writeEnable,
    input  logic                readEnable,
    input  logic [29:0]         memAddress,
    output logic [31:0]         readData,
    output logic [NUM_LEDS-1:0] leds
);

    logic [2:0]            reg_sel;
    logic [NUM_LEDS-1:0]   led_on;
    logic [PWM_BITS-1:0]   duty;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  pwm_on;
    logic [NUM_LEDS-1:0]   blink_mask;
    logic [BLINK_BITS-1:0] blink_half;
    logic                  blink_phase;
    logic [31:0]           status;
    logic                  unused_bits;

    // Register decode happens upstream; only the low three word-address bits matter here.
    assign reg_sel     = memAddress[2:0];
    assign unused_bits = ^{memAddress[29:3], writeData};

    always_ff @(posedge clk) begin
        if (rst) begin
            led_on  <= '0;
            duty    <= '1;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (writeEnable && reg_sel == 3'd0) led_on <= writeData[NUM_LEDS-1:0];
            if (writeEnable && reg_sel == 3'd1) duty   <= writeData[PWM_BITS-1:0];
        end
    end

`ifdef LED_BLINK_EN
    logic [BLINK_BITS-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_mask  <= '0;
            blink_half  <= BLINK_BITS'(BLINK_RST);
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (writeEnable && reg_sel == 3'd2) blink_mask <= writeData[NUM_LEDS-1:0];
            // Reprogramming the half-period restarts the blink from a known phase.
            if (writeEnable && reg_sel == 3'd3) begin
                blink_half  <= writeData[BLINK_BITS-1:0];
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == blink_half) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_BITS'(1);
            end
        end
    end
`else
    assign blink_mask  = '0;
    assign blink_half  = '0;
    assign blink_phase = 1'b1;
`endif

    // All-ones duty is fully on so that the reset brightness is truly 100%.
    assign pwm_on = (&duty) | (pwm_cnt < duty);

    always_ff @(posedge clk) begin
        if (rst) leds <= '0;
        else     leds <= led_on & {NUM_LEDS{pwm_on}} & (~blink_mask | {NUM_LEDS{blink_phase}});
    end

    assign status = 32'(pwm_cnt) | (32'(blink_phase) << 16);

    always_comb begin
        readData = 32'd0;
        if (readEnable) begin
            case (reg_sel)
                3'd0:    readData = 32'(led_on);
                3'd1:    readData = 32'(duty);
                3'd2:    readData = 32'(blink_mask);
                3'd3:    readData = 32'(blink_half);
                3'd4:    readData = status;
                default: readData = 32'd0;
            endcase
        end
    end

endmodule
